// File: rtl/inv_shift_rows_buffer_if.sv
// Column handshake bundle between the round datapath and the (Inv)ShiftRows buffer.
// master drives input columns and output acceptance; slave is the buffer itself.
// Valid/ready on both sides; a transfer happens when valid and ready are both high.
interface inv_shift_rows_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_col;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_col;
    logic        out_last;

    modport master (
        output in_valid, in_col, out_ready,
        input  in_ready, out_valid, out_col, out_last
    );

    modport slave (
        input  in_valid, in_col, out_ready,
        output in_ready, out_valid, out_col, out_last
    );
endinterface

// File: rtl/inv_shift_rows_buffer.sv
// Column-serial AES (Inv)ShiftRows: buffers a 4-column state, emits row-shifted columns.
// Latency: first out_valid the cycle after the 4th input accept; ISR_PINGPONG_EN adds a second bank.
// Backpressure: output holds while out_valid & !out_ready; in_ready drops when no bank is free.
module inv_shift_rows_buffer #(
    parameter int unsigned SHIFT_DIR = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    inv_shift_rows_buffer_if.slave bus
);
    logic [1:0]  wr_cnt;
    logic [1:0]  rd_cnt;
    logic        in_fire;
    logic        out_fire;
    logic        wr_a;
    logic [7:0]  bank_a [4][4];
    logic [1:0]  rd_col [4];
    logic [31:0] shifted;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

`ifdef ISR_PINGPONG_EN
    logic [7:0] bank_b [4][4];
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_bank;
    logic       rd_bank;
    logic       wr_b;

    // wr_bank always points at the next bank to fill, so it being full means both are full
    assign bus.in_ready  = ~full[wr_bank];
    assign bus.out_valid = full[rd_bank];
    assign wr_a = in_fire & ~clear & ~wr_bank;
    assign wr_b = in_fire & ~clear & wr_bank;

    // Fill and drain touch different banks, so both updates can land in one cycle
    always_comb begin
        full_nxt = full;
        if (in_fire && wr_cnt == 2'd3) full_nxt[wr_bank] = 1'b1;
        if (out_fire && rd_cnt == 2'd3) full_nxt[rd_bank] = 1'b0;
    end

    // Bank occupancy and fill/drain pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else if (clear) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            full <= full_nxt;
            if (in_fire && wr_cnt == 2'd3) wr_bank <= ~wr_bank;
            if (out_fire && rd_cnt == 2'd3) rd_bank <= ~rd_bank;
        end
    end

    // Second bank storage; survives clear, zeroed only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    bank_b[2'(r)][2'(c)] <= 8'h00;
        end else if (wr_b) begin
            for (int r = 0; r < 4; r++)
                bank_b[2'(r)][wr_cnt] <= bus.in_col[31-8*r -: 8];
        end
    end
`else
    typedef enum logic {FILL, DRAIN} state_t;
    state_t state;
    state_t state_nxt;

    assign bus.in_ready  = (state == FILL);
    assign bus.out_valid = (state == DRAIN);
    assign wr_a = in_fire & ~clear;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    // FSM next state: a full block flips to DRAIN, the 4th output returns to FILL
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:    if (in_fire && wr_cnt == 2'd3) state_nxt = DRAIN;
                DRAIN:   if (out_fire && rd_cnt == 2'd3) state_nxt = FILL;
                default: state_nxt = FILL;
            endcase
        end
    end
`endif

    // Column counters wrap naturally at 4 so each block restarts at column 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= 2'd0;
            rd_cnt <= 2'd0;
        end else if (clear) begin
            wr_cnt <= 2'd0;
            rd_cnt <= 2'd0;
        end else begin
            if (in_fire)  wr_cnt <= wr_cnt + 2'd1;
            if (out_fire) rd_cnt <= rd_cnt + 2'd1;
        end
    end

    // Primary bank storage, indexed [row][column]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    bank_a[2'(r)][2'(c)] <= 8'h00;
        end else if (wr_a) begin
            for (int r = 0; r < 4; r++)
                bank_a[2'(r)][wr_cnt] <= bus.in_col[31-8*r -: 8];
        end
    end

    // Source column per row: inverse shifts row r right by r, forward shifts it left by r
    always_comb begin
        rd_col = '{default: 2'd0};
        for (int r = 0; r < 4; r++)
            rd_col[r] = (SHIFT_DIR != 0) ? rd_cnt + 2'(r) : rd_cnt - 2'(r);
    end

    // Output column gathered from registered bank bytes only
    always_comb begin
        shifted = 32'h0;
        for (int r = 0; r < 4; r++) begin
`ifdef ISR_PINGPONG_EN
            shifted[31-8*r -: 8] = rd_bank ? bank_b[2'(r)][rd_col[r]] : bank_a[2'(r)][rd_col[r]];
`else
            shifted[31-8*r -: 8] = bank_a[2'(r)][rd_col[r]];
`endif
        end
    end

    assign bus.out_col  = bus.out_valid ? shifted : 32'h0;
    assign bus.out_last = bus.out_valid & (rd_cnt == 2'd3);
endmodule

// File: doc/inv_shift_rows_buffer.md
Name: inv_shift_rows_buffer

Overview:
- Column-serial AES InvShiftRows stage, placed directly downstream of reverse_mix_cols in the decryption round datapath.
- Accepts one 32-bit state column per handshake, buffers a full 128-bit state (4 columns), then emits the row-shifted state one column per handshake.
- Needed because InvShiftRows mixes bytes across columns; no output column can be formed until all four input columns are held.

Parameters:
- SHIFT_DIR, 0, 0 = inverse shift rows (decrypt); 1 = forward shift rows (encrypt path reuse).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; discards any partial or pending block.
- in_valid  input  1  in_col is valid.
- in_ready  output  1  block can accept a column this cycle.
- in_col  input  32  state column; byte row0 = [31:24], row1 = [23:16], row2 = [15:8], row3 = [7:0].
- out_valid  output  1  out_col is valid.
- out_ready  input  1  downstream accepts out_col this cycle.
- out_col  output  32  shifted column, same byte order as in_col.
- out_last  output  1  high with the 4th (column 3) output of each block.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - in_ready = 1, out_valid = 0, out_last = 0, out_col = 0.
  - Write/read column counters = 0; all bank bytes = 0; FSM = FILL.
- Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
- Column counters are 2-bit and wrap 3 -> 0.
- Input column counter wr_cnt selects the bank column written. Column index is implicit: the first accepted column after reset, clear or block end is column 0.
- FSM, single-bank build:
  - FILL: in_ready = 1, out_valid = 0. The 4th accepted input moves the FSM to DRAIN on the next edge.
  - DRAIN: in_ready = 0, out_valid = 1. Each output accept increments rd_cnt. The accept at rd_cnt = 3 moves the FSM to FILL.
- Output mapping: out_col row r byte = bank[r][(rd_cnt - r) mod 4] for SHIFT_DIR = 0, or bank[r][(rd_cnt + r) mod 4] for SHIFT_DIR = 1.
  - out_col is formed from registered state only, with no combinational path from inputs.
  - out_last = out_valid & (rd_cnt == 3).
- Latency: first out_valid is asserted the cycle after the 4th input accept. Best-case throughput is one column per cycle on each side; the single-bank build is 8 cycles per block.
- Backpressure: while out_valid & !out_ready, out_col and out_last hold stable and nothing advances.
- in_valid while in_ready = 0: ignored; the upstream source must hold the data.
- clear (higher priority than either handshake):
  - Next edge returns the FSM to FILL and zeroes both counters.
  - out_valid drops and any partial block is lost.
  - Bank contents are not cleared.
- Reset mid-block: same as clear, plus all banks are zeroed.

Optional Feature:
- Macro ISR_PINGPONG_EN.
- Defined:
  - Two banks with independent fill and drain pointers. Bank B fills while bank A drains.
  - in_ready = 0 only when both banks are full.
  - A 4th input accept and a 4th output accept in the same cycle are both honoured: one bank becomes full, the other becomes free, and in_ready stays 1.
  - Sustained throughput is 4 cycles per block.
  - clear empties both banks.
- Undefined: single-bank FSM as described above.

Test Plan:
- Basic inverse: SHIFT_DIR = 0, feed 00112233, 44556677, 8899aabb, ccddeeff with out_ready = 1. Required outputs are 00ddaa77, 4411eebb, 885522ff, cc996633, with out_last on the 4th only, and first out_valid one cycle after the 4th input.
- Forward: SHIFT_DIR = 1, same inputs. Required outputs are 0055aaff, 4499ee33, 88dd2277, cc1166bb.
- Backpressure: hold out_ready = 0 for 5 cycles during column 1 of the output. out_col stays 4411eebb, in_ready = 0 (single-bank build), and the remaining outputs are unchanged in order.
- Clear mid-fill: accept 2 columns, pulse clear, then feed the full 4-column block. Output matches the basic case exactly, with no stale columns.
- Reset mid-drain: drop rst_n after 2 outputs. out_valid = 0 and in_ready = 1 immediately (asynchronous), out_col = 0. A subsequent block behaves normally.
- ISR_PINGPONG_EN: stream 3 back-to-back blocks with in_valid = 1 and out_ready = 1. in_ready never drops, 12 outputs are in order, and block 2 output starts exactly 4 cycles after block 1's.
